// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit
// Multi-cycle load/store unit that sits between the core and a wait-stated memory.
// It takes one core request at a time and turns it into an aligned, byte-enabled memory access
// over a req/ack handshake. Load data is extracted from its lane and then sign- or zero-extended.
// Misaligned addresses and illegal sizes are reported as errors, and no memory access is made.
// Optional feature: define LSU_TIMEOUT_EN to abandon an access after 2**TIMEOUT_W-1 cycles
// without mem_ack. When the macro is undefined, the unit waits for mem_ack indefinitely.
module mips_load_store_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic              req_err;
    logic              timeout;

    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [OFF_W-1:0]  offset;
    logic [NB-1:0]     be_base;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] shifted;
    logic              fill;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_ext;

    assign accept = req_valid && (state == IDLE);

    // Flag requests whose address is not a multiple of their size, or that use dword on a 32-bit bus
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = (DATA_W != 64) || (|req_addr[2:0]);
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    logic [TIMEOUT_W-1:0] wait_cnt;

    // Count ACCESS cycles that see no ack; the count restarts whenever a new access begins
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !mem_ack) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        end
    end

    // The terminal wait cycle times out unless an ack arrives in that same cycle
    assign timeout = (state == ACCESS) && !mem_ack && (wait_cnt == WAIT_LAST);
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_W;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; erroring requests skip the memory and go straight to the response
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request at acceptance, then capture load data on ack or flag a timeout
    always_ff @(posedge clock) begin
        if (!reset) begin
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (accept) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= '0;
        end else if (state == ACCESS) begin
            if (mem_ack) begin
                if (!write_q) rdata_q <= load_ext;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // Lane steering: byte enables, store-data replication and load extraction/extension
    always_comb begin
        offset = addr_q[OFF_W-1:0];
        case (size_q)
            2'b00:   be_base = NB'(1);
            2'b01:   be_base = NB'(3);
            2'b10:   be_base = NB'(15);
            default: be_base = '1;
        endcase
        be      = be_base << offset;
        shifted = mem_rdata >> {offset, 3'b000};
        case (size_q)
            2'b00:   fill = signed_q && shifted[7];
            2'b01:   fill = signed_q && shifted[15];
            2'b10:   fill = signed_q && shifted[31];
            default: fill = signed_q && shifted[DATA_W-1];
        endcase
        wdata_rep = '0;
        load_ext  = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = wdata_q[8*(i & ((1 << size_q) - 1)) +: 8];
            load_ext[8*i +: 8]  = (i < (1 << size_q)) ? shifted[8*i +: 8] : {8{fill}};
        end
    end

    // Outputs are driven from the state; memory outputs are zero outside ACCESS
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        mem_req   = (state == ACCESS);
        mem_we    = mem_req && write_q;
        mem_addr  = mem_req ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
        mem_be    = mem_req ? be : '0;
        mem_wdata = (mem_req && write_q) ? wdata_rep : '0;
        rsp_valid = (state == RESP);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid && err_q;
    end

endmodule
